// File: rtl/run_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_gen_if : request handshake and serial-line bundle for run_gen     |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
interface run_gen_if #(
  parameter int LW = 4
);
  logic          in_valid;
  logic [LW-1:0] in_len;
  logic          in_ready;
  logic          o;
  logic          busy;
  logic          done;
  logic [7:0]    runs;

  modport master (
    output in_valid, in_len,
    input  in_ready, o, busy, done, runs
  );

  modport slave (
    input  in_valid, in_len,
    output in_ready, o, busy, done, runs
  );
endinterface
`default_nettype wire

// File: rtl/run_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_gen : drives o high for a requested number of cycles, then holds  |
// |           it low for GAP cycles; one rising edge per accepted request |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module run_gen #(
  parameter int LW  = 4,
  parameter int GAP = 2
) (
  input  wire logic   clk,
  input  wire logic   reset,
  run_gen_if.slave    bus
);

  localparam int          c_GW       = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [LW-1:0]   c_CNT_ONE  = LW'(1);
  localparam logic [c_GW-1:0] c_GCNT_ONE = c_GW'(1);
  localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [LW-1:0]   r_cnt,   w_cnt_nxt;
  logic [c_GW-1:0] r_gcnt,  w_gcnt_nxt;
  logic            r_done,  w_done_nxt;
  logic [7:0]      r_runs,  w_runs_nxt;
  logic            w_o, w_busy, w_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_done  <= 1'b0;
      r_runs  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_done  <= w_done_nxt;
      r_runs  <= w_runs_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gcnt_nxt  = r_gcnt;
    w_done_nxt  = 1'b0;
    w_runs_nxt  = r_runs;
    w_o         = 1'b0;
    w_busy      = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        // A zero-length request is consumed here but never starts a run.
        if (bus.in_valid && (bus.in_len != '0)) begin
          w_cnt_nxt   = bus.in_len;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_o       = 1'b1;
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_gcnt_nxt  = c_GAP_LOAD;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_busy     = 1'b1;
        w_gcnt_nxt = r_gcnt - c_GCNT_ONE;
        if (r_gcnt == c_GCNT_ONE) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_runs_nxt  = r_runs + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.o        = w_o;
  assign bus.busy     = w_busy;
  assign bus.in_ready = w_ready;
  assign bus.done     = r_done;
  assign bus.runs     = r_runs;

endmodule
`default_nettype wire

// File: tb/tb_run_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_run_gen : table, hand-written and random tests of run_gen against  |
// |              a queue-based model of the serial line                   |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_run_gen;
  localparam int LW  = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  run_gen_if #(.LW(LW)) bus ();
  run_gen #(.LW(LW), .GAP(GAP)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Model: q holds the expected o value for each upcoming busy cycle.
  bit q[$];
  int exp_runs;
  bit exp_done;
  bit last_hs;
  int checks, failures;
  int edges, dones, high_cnt, low_len, min_low;
  bit seen_high;
  logic prev_o;

  typedef struct {
    logic [LW-1:0] len;
    int            exp_high;
    int            exp_done_at;
  } vec_t;
  vec_t tbl[6];

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs(input string name);
    logic [11:0] act, exp;
    logic eo;
    eo  = (q.size() > 0) ? q[0] : 1'b0;
    exp = {eo, q.size() != 0, q.size() == 0, exp_done, exp_runs[7:0]};
    act = {bus.o, bus.busy, bus.in_ready, bus.done, bus.runs};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual{o,busy,rdy,done,runs}=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_runs = 0;
    exp_done = 1'b0;
    last_hs  = 1'b0;
    prev_o   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (q.size() > 0) begin
      void'(q.pop_front());
      last_hs = 1'b0;
      if (q.size() == 0) begin
        exp_done = 1'b1;
        exp_runs = (exp_runs + 1) % 256;
      end else begin
        exp_done = 1'b0;
      end
    end else begin
      exp_done = 1'b0;
      last_hs  = bus.in_valid;
      if (bus.in_valid && bus.in_len != 0) begin
        for (int i = 0; i < int'(bus.in_len); i++) q.push_back(1'b1);
        for (int i = 0; i < GAP; i++) q.push_back(1'b0);
      end
    end
    @(negedge clk);
    check_outputs("cycle");
    if (bus.o === 1'b1) begin
      high_cnt++;
      if (prev_o !== 1'b1) begin
        edges++;
        if (seen_high && low_len < min_low) min_low = low_len;
      end
      seen_high = 1'b1;
      low_len   = 0;
    end else begin
      low_len++;
    end
    if (bus.done === 1'b1) dones++;
    prev_o = bus.o;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      step();
      n++;
    end
    if (q.size() > 0) check_int("wait_idle_timeout", n, -1);
  endtask

  task automatic clear_stats();
    edges = 0; dones = 0; high_cnt = 0; low_len = 0;
    min_low = 1000; seen_high = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int runs0, done_at, n, hs;
    logic [LW-1:0] lens [3];

    checks = 0; failures = 0;
    bus.in_valid = 1'b0;
    bus.in_len   = '0;
    model_reset();
    clear_stats();
    repeat (2) @(negedge clk);
    check_outputs("reset_state");
    reset = 1'b0;

    // Table: length, expected high cycles, cycle index of done after handshake.
    tbl[0] = '{4'd3,  3,  6};
    tbl[1] = '{4'd1,  1,  4};
    tbl[2] = '{4'd15, 15, 18};
    tbl[3] = '{4'd2,  2,  5};
    tbl[4] = '{4'd0,  0,  0};
    tbl[5] = '{4'd7,  7,  10};
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      clear_stats();
      done_at = 0;
      bus.in_valid = 1'b1;
      bus.in_len   = tbl[i].len;
      for (int c = 1; c <= 25; c++) begin
        step();
        if (c == 1) bus.in_valid = 1'b0;
        if (bus.done === 1'b1 && done_at == 0) done_at = c;
      end
      check_int($sformatf("tbl%0d_high", i), high_cnt, tbl[i].exp_high);
      check_int($sformatf("tbl%0d_done_at", i), done_at, tbl[i].exp_done_at);
    end
    check_int("tbl_runs", int'(bus.runs), 5);

    // Back-to-back with in_valid held high: lengths 1, 15, 2.
    lens[0] = 4'd1; lens[1] = 4'd15; lens[2] = 4'd2;
    wait_idle();
    clear_stats();
    runs0 = exp_runs;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_len = lens[i];
      n = 0;
      do begin
        step();
        n++;
      end while (!last_hs && n < 40);
      if (!last_hs) check_int("b2b_hs_timeout", n, -1);
    end
    bus.in_valid = 1'b0;
    wait_idle();
    step();
    check_int("b2b_edges", edges, 3);
    check_int("b2b_dones", dones, 3);
    check_int("b2b_high", high_cnt, 18);
    check_int("b2b_min_low", int'(min_low >= GAP + 1), 1);
    check_int("b2b_runs", int'(bus.runs), (runs0 + 3) % 256);

    // Inputs changing while busy must not disturb the run in progress.
    wait_idle();
    clear_stats();
    bus.in_valid = 1'b1;
    bus.in_len   = 4'd4;
    step();
    n = 0;
    while (q.size() > 0 && n < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_len   = LW'($urandom_range(0, 15));
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    check_int("busy_ignore_high", high_cnt, 4);
    check_int("busy_ignore_len", n, 4 + GAP);

    // Asynchronous reset in the middle of a length-10 run.
    step();
    bus.in_valid = 1'b1;
    bus.in_len   = 4'd10;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset_mid_run");
    check_int("reset_o_low", int'(bus.o), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    bus.in_valid = 1'b1;
    bus.in_len   = 4'd2;
    step();
    bus.in_valid = 1'b0;
    wait_idle();
    check_int("post_reset_high", high_cnt, 2);
    check_int("post_reset_runs", int'(bus.runs), 1);

    // 256 length-1 runs: the counter wraps back to zero.
    do_reset();
    clear_stats();
    bus.in_valid = 1'b1;
    bus.in_len   = 4'd1;
    hs = 0;
    n  = 0;
    while (hs < 256 && n < 2000) begin
      step();
      if (last_hs) hs++;
      n++;
    end
    bus.in_valid = 1'b0;
    wait_idle();
    check_int("wrap_handshakes", hs, 256);
    check_int("wrap_dones", dones, 256);
    check_int("wrap_runs", int'(bus.runs), 0);
    check_int("wrap_min_low", int'(min_low >= GAP + 1), 1);
    check_int("wrap_high", high_cnt, 256);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_len   = LW'($urandom_range(0, 15));
      step();
    end
    bus.in_valid = 1'b0;
    wait_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/run_gen.md
# run_gen

Serial run generator: accepts a run-length request over a valid/ready handshake and drives a single-bit serial line high for exactly that many clock cycles, then holds it low for a fixed guard gap. It is the transmit side of the team's serial edge-detect path. Each accepted request produces exactly one 0→1 transition on `o`, so a downstream rising-edge detector emits exactly one pulse per request. It sits between a control source issuing lengths and the serial line feeding the detector.

## Interface
- `LW`, default 4: width of the run-length field; legal lengths are 1..2^LW-1.
- `GAP`, default 2: number of guaranteed low cycles after every run; legal range is at least 1.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset; clock `clk`.
- `in_valid` in 1: request present.
- `in_len` in LW: requested run length; sampled only on handshake.
- `in_ready` out 1: block can accept a request (high only in IDLE).
- `o` out 1: serial output line.
- `busy` out 1: high in RUN or GAP.
- `done` out 1: one-cycle pulse when a run and its gap complete.
- `runs` out 8: count of completed runs; wraps 255→0.

## Operation
- FSM states: IDLE, RUN, GAP. All outputs are Moore/registered; none are combinationally driven by inputs.
- IDLE: `o`=0, `in_ready`=1, `busy`=0.
  - Handshake occurs when `in_valid`&`in_ready` at a clock edge.
  - If `in_len`≠0: load `cnt`←`in_len` and go to RUN.
  - If `in_len`=0: the request is consumed and dropped. Stay in IDLE, no `done`, `runs` unchanged.
- RUN: `o`=1, `in_ready`=0, `busy`=1. `cnt` decrements each cycle.
  - When `cnt`=1: load `gcnt`←GAP and go to GAP.
- GAP: `o`=0, `in_ready`=0, `busy`=1. `gcnt` decrements each cycle.
  - When `gcnt`=1: go to IDLE, assert `done` for the next cycle, and increment `runs` (mod 256).
- `in_valid` and `in_len` are ignored outside IDLE. The source must hold the request until `in_ready`.
- No other state encoding is reachable. Any illegal encoding returns to IDLE on the next edge with `o`=0.
- `cnt` is LW bits and `gcnt` is ceil(log2(GAP+1)) bits. Neither counter underflows, because the exit condition is tested at 1.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `o`=0, `in_ready`=1, `busy`=0, `done`=0, `runs`=0, `cnt`=0, `gcnt`=0.
- Reset asserted mid-RUN forces `o` low without waiting for a clock edge. The in-flight run is discarded and does not count.
- For a handshake at edge k with length L:
  - `o`=1 during cycles k+1 … k+L (exactly L cycles).
  - `o`=0 and `busy`=1 during cycles k+L+1 … k+L+GAP.
  - During cycle k+L+GAP+1: `done`=1, `runs` has incremented, and `in_ready`=1.
- Back-to-back requests (`in_valid` held high): the next handshake is at the end of cycle k+L+GAP+1, so requests are spaced L+GAP+1 cycles apart. There are at least GAP+1 low cycles between runs.
- `done` and `in_ready` coincide in the first IDLE cycle. A new handshake in that same cycle is legal. `done` stays a single-cycle pulse.
- Maximum length 2^LW-1 (15 at default) produces 15 high cycles. There is no wrap in `cnt`.

## Test plan
- Reset, then `in_valid`=1 with `in_len`=3 at edge 1 → `o` high during cycles 2–4, low during 5–6, `done`=1 and `in_ready`=1 in cycle 7, `runs`=1.
- Hold `in_valid` high with lengths 1, 15, 2 (GAP=2) → `o` patterns are 1 high, 15 high, 2 high, each followed by at least 3 low cycles. `done` pulses 3 times, `runs`=3, and a downstream rising-edge detector counts exactly 3 edges.
- `in_len`=0 with `in_valid`=1 → `in_ready` stays 1, `o` stays 0, no `done`, `runs` unchanged. A following `in_len`=1 request then produces a 1-cycle high.
- Assert `reset` asynchronously mid-RUN of a length-10 request → `o`=0 and `busy`=0 immediately, `runs`=0. A new length-2 request after release produces a 2-cycle high.
- Change `in_len` and toggle `in_valid` while `busy`=1 → no effect on the current run or gap length. The request is taken only once `in_ready`=1.
- Issue 256 length-1 requests → `runs` reads 0 after the 256th `done`. Every run is 1 high followed by 2 low cycles.
